hilo_mul_div: RTL and testbench
===============================

// Module: hilo_mul_div
// PURPOSE
//  Iterative multiply/divide unit with HI/LO result registers. Sits directly downstream of the
//  register file: consumes Rs_Data/Rt_Data read ports, runs MULT/MULTU/DIV/DIVU over WIDTH cycles,
//  and holds the 64-bit result in Hi/Lo. Hi/Lo are later selected (MFHI/MFLO) into the Rd_Data write path.
//  One clock, clk; reset rst is synchronous, active-high.
// PARAMETERS
//  WIDTH  32  operand width. Hi/Lo are each WIDTH bits. Iteration count = WIDTH.
// PORTS
//  clk      in   1      clock; all state updates on rising edge
//  rst      in   1      synchronous active-high reset
//  start    in   1      request an operation; sampled only when busy=0
//  op       in   2      00 MULTU, 01 DIVU, 10 MULT (signed), 11 DIV (signed)
//  Rs_Data  in   WIDTH  multiplicand / dividend; also MTHI/MTLO source
//  Rt_Data  in   WIDTH  multiplier / divisor
//  hi_we    in   1      MTHI: Hi <= Rs_Data (only when idle)
//  lo_we    in   1      MTLO: Lo <= Rs_Data (only when idle)
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse; Hi/Lo hold the new result
//  Hi       out  WIDTH  HI register (product upper half / remainder)
//  Lo       out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  - Reset: busy=0, done=0, Hi=0, Lo=0, FSM=IDLE, internal accumulators cleared. Applies in any state;
//    an operation in flight is aborted and its result discarded.
//  - FSM: IDLE -> CALC (start=1 at edge) -> CALC for WIDTH edges -> FIX (1 edge) -> DONE (1 cycle) -> IDLE.
//    DONE also accepts start (DONE -> CALC directly).
//  - Latency: start high in cycle C. busy=1 in cycles C+1..C+WIDTH+1. Hi/Lo written at the end of C+WIDTH+1.
//    done=1, busy=0 in cycle C+WIDTH+2.
//  - start, op, Rs_Data and Rt_Data are latched at the accepting edge. Input changes while busy have no effect.
//  - start while busy=1 is ignored. No queuing.
//  - Signed ops: operands are converted to magnitudes at accept, and the iteration is unsigned.
//    FIX applies signs:
//      product is negated iff operand signs differ;
//      quotient is negated iff signs differ;
//      remainder takes the dividend's sign.
//  - MULT/MULTU: shift-add, one multiplier bit per CALC cycle. Full 2*WIDTH-bit product.
//    Hi = upper half, Lo = lower half.
//  - DIV/DIVU: restoring division, one quotient bit per CALC cycle. Lo = quotient, Hi = remainder.
//  - Divide by zero: full latency still taken. Lo = {WIDTH{1'b1}}, Hi = Rs_Data as latched (both signednesses).
//  - Signed overflow (DIV, Rs=0x80000000, Rt=0xFFFFFFFF): Lo = 0x80000000, Hi = 0.
//  - hi_we/lo_we: honoured only in IDLE or DONE. Effect visible the next cycle. Both may fire together.
//    The same edge as an accepted start: start accepted AND the write is applied.
//    The FIX write later overwrites it.
//  - Hi/Lo otherwise hold their value indefinitely. Result of the last completed op stays until the next FIX or MT.
// STRUCTURE
//  - Shared package: op encodings (OP_MULTU..OP_DIV), FSM state encodings (IDLE, CALC, FIX, DONE),
//    DIV0_LO constant.
//  - Single module. Datapath is one 2*WIDTH-bit shift register shared by mul and div, plus a $clog2(WIDTH+1) counter.
//  - No sub-module. Sign pre/post logic is small enough to stay inline.
// TESTING
//  1. MULTU Rs=0xFFFFFFFF, Rt=0x00000002 -> done at C+34; Hi=0x00000001, Lo=0xFFFFFFFE.
//  2. MULT Rs=0xFFFFFFFD (-3), Rt=0x00000007 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
//  3. DIV Rs=0xFFFFFFF9 (-7), Rt=0x00000002 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
//     DIVU Rs=100, Rt=7 -> Lo=14, Hi=2.
//  4. DIVU Rs=0x12345678, Rt=0 -> Lo=0xFFFFFFFF, Hi=0x12345678, done at C+34.
//     DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
//  5. start pulsed again at C+5 with new operands -> ignored, first result intact.
//     rst at C+10 -> busy=0, Hi=Lo=0, no done pulse.
//  6. lo_we Rs=0xCAFEBABE in IDLE -> Lo=0xCAFEBABE next cycle. lo_we while busy -> Lo unchanged.
//     start accepted in DONE -> back-to-back results, done spaced 34 cycles.

Source files
------------

// File: rtl/hilo_mul_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mul_div_pkg
// Description : Shared op codes, FSM states and constants for hilo_mul_div.
// Revision    : 1.0
// ============================================================================
package hilo_mul_div_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Divide-by-zero quotient pattern; sliced to the operand width at use.
    localparam logic [63:0] DIV0_LO = '1;

endpackage
`default_nettype wire

// File: rtl/hilo_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mul_div
// Description : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Revision    : 1.0
// ============================================================================
module hilo_mul_div
    import hilo_mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Rs_Data,
    input  logic [WIDTH-1:0] Rt_Data,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_rs;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div0;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_open;
    logic                 w_accept;
    logic                 w_rs_neg;
    logic                 w_rt_neg;
    logic [WIDTH-1:0]     w_rs_mag;
    logic [WIDTH-1:0]     w_rt_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_rem;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign w_open   = (r_state == IDLE) || (r_state == DONE);
    assign w_accept = start && w_open;

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    assign w_rs_neg = op[1] & Rs_Data[WIDTH-1];
    assign w_rt_neg = op[1] & Rt_Data[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -Rs_Data : Rs_Data;
    assign w_rt_mag = w_rt_neg ? -Rt_Data : Rt_Data;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division: remainder in the high half, quotient shifts into the low half.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    always_comb begin
        w_div_rem = w_div_shift[WIDTH-1:0];
        if (w_div_ge) begin
            w_div_rem = w_div_shift[WIDTH-1:0] - r_opb;
        end
    end
    assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (r_cnt == c_cnt_one) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? CALC : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_rs     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_acc    <= {{WIDTH{1'b0}}, (op[0] ? w_rs_mag : w_rt_mag)};
            r_opb    <= op[0] ? w_rt_mag : w_rs_mag;
            r_rs     <= Rs_Data;
            r_is_div <= op[0];
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_div0   <= op[0] && (Rt_Data == '0);
            r_cnt    <= c_cnt_init;
        end else if (r_state == CALC) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    // MT writes land on the accept edge too; the FIX write later supersedes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == FIX) begin
            if (!r_is_div) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end else if (r_div0) begin
                r_hi <= r_rs;
                r_lo <= DIV0_LO[WIDTH-1:0];
            end else begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end
        end else if (w_open) begin
            if (hi_we) r_hi <= Rs_Data;
            if (lo_we) r_lo <= Rs_Data;
        end
    end

    assign busy = (r_state == CALC) || (r_state == FIX);
    assign done = (r_state == DONE);
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mul_div
// Description : Self-checking bench for hilo_mul_div against an arithmetic model.
// Revision    : 1.0
// ============================================================================
module tb_hilo_mul_div;
    import hilo_mul_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         hi_we;
    logic         lo_we;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hilo_mul_div #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .Rs_Data (rs),
        .Rt_Data (rt),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .busy    (busy),
        .done    (done),
        .Hi      (hi),
        .Lo      (lo)
    );

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            OP_MULT:  begin p = 64'(sa * sb);            eh = p[63:32]; el = p[31:0]; end
            OP_DIVU: begin
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin eh = a % b; el = a / b; end
            end
            default: begin
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin p = 64'(sa % sb); eh = p[31:0]; p = 64'(sa / sb); el = p[31:0]; end
            end
        endcase
    endfunction

    // Counts edges until done is seen; gives up after 100.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done !== 1'b1 && n < 100);
    endtask

    task automatic issue_and_wait(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output int n);
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); rs = $urandom; rt = $urandom;
        wait_done(n);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00; rs = '0; rt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", done); end
        if (hi !== '0) begin n_errors++; $display("FAIL reset_hi got=%h want=0", hi); end
        if (lo !== '0) begin n_errors++; $display("FAIL reset_lo got=%h want=0", lo); end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    task automatic test_directed();
        vec_t v[9];
        int   n;
        v[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE};
        v[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        v[4] = '{OP_DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF};
        v[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        v[6] = '{OP_DIV,   32'h8000_0000, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF};
        v[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        v[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        for (int i = 0; i < 9; i++) begin
            issue_and_wait(v[i].o, v[i].a, v[i].b, n);
            n_checks += 3;
            if (n != LAT) begin n_errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, n, LAT); end
            if (hi !== v[i].eh) begin n_errors++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, v[i].eh); end
            if (lo !== v[i].el) begin n_errors++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, v[i].el); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        int          n;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: a = 32'h8000_0000;
                2: b = 32'($urandom_range(1, 20));
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(o, a, b, eh, el);
            issue_and_wait(o, a, b, n);
            n_checks += 4;
            if (n != LAT) begin n_errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, n, LAT); end
            if (hi !== eh) begin n_errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, hi, eh); end
            if (lo !== el) begin n_errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, lo, el); end
            @(posedge clk); #1;
            if (done !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] eh, el;
        int          n;
        model(OP_MULT, 32'hFFFF_FF00, 32'h0001_2345, eh, el);
        start = 1'b1; op = OP_MULT; rs = 32'hFFFF_FF00; rt = 32'h0001_2345;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = OP_DIVU; rs = 32'd99; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        n_checks += 5;
        if (n != LAT - 5) begin n_errors++; $display("FAIL ignore_latency got=%0d want=%0d", n, LAT - 5); end
        if (hi !== eh) begin n_errors++; $display("FAIL ignore_hi got=%h want=%h", hi, eh); end
        if (lo !== el) begin n_errors++; $display("FAIL ignore_lo got=%h want=%h", lo, el); end
        @(posedge clk); #1;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL ignore_no_queue_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL ignore_no_queue_done got=%b want=0", done); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        start = 1'b1; op = OP_MULTU; rs = 32'h1234_5678; rt = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (hi !== '0) begin n_errors++; $display("FAIL abort_hi got=%h want=0", hi); end
        if (lo !== '0) begin n_errors++; $display("FAIL abort_lo got=%h want=0", lo); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        if (pulses != 0) begin n_errors++; $display("FAIL abort_done_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_mt();
        int n;
        rs = 32'hCAFE_BABE; lo_we = 1'b1;
        @(posedge clk); #1;
        lo_we = 1'b0;
        n_checks += 2;
        if (lo !== 32'hCAFE_BABE) begin n_errors++; $display("FAIL mtlo_idle got=%h want=cafebabe", lo); end
        if (hi !== '0) begin n_errors++; $display("FAIL mtlo_hi_kept got=%h want=0", hi); end
        rs = 32'h1357_9BDF; hi_we = 1'b1; lo_we = 1'b1;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks += 2;
        if (hi !== 32'h1357_9BDF) begin n_errors++; $display("FAIL mt_both_hi got=%h want=13579bdf", hi); end
        if (lo !== 32'h1357_9BDF) begin n_errors++; $display("FAIL mt_both_lo got=%h want=13579bdf", lo); end
        start = 1'b1; op = OP_MULTU; rs = 32'd3; rt = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; rs = 32'hDEAD_BEEF; lo_we = 1'b1; hi_we = 1'b1;
        @(posedge clk); #1;
        lo_we = 1'b0; hi_we = 1'b0;
        n_checks += 2;
        if (lo !== 32'h1357_9BDF) begin n_errors++; $display("FAIL mtlo_busy got=%h want=13579bdf", lo); end
        if (hi !== 32'h1357_9BDF) begin n_errors++; $display("FAIL mthi_busy got=%h want=13579bdf", hi); end
        wait_done(n);
        n_checks += 2;
        if (hi !== 32'd0) begin n_errors++; $display("FAIL mt_busy_result_hi got=%h want=0", hi); end
        if (lo !== 32'd15) begin n_errors++; $display("FAIL mt_busy_result_lo got=%h want=f", lo); end
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIVU; rs = 32'd50; rt = 32'd8; hi_we = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        n_checks += 2;
        if (hi !== 32'd50) begin n_errors++; $display("FAIL mt_with_start_hi got=%h want=32", hi); end
        if (busy !== 1'b1) begin n_errors++; $display("FAIL mt_with_start_busy got=%b want=1", busy); end
        wait_done(n);
        n_checks += 3;
        if (n != LAT) begin n_errors++; $display("FAIL mt_with_start_latency got=%0d want=%0d", n, LAT); end
        if (hi !== 32'd2) begin n_errors++; $display("FAIL mt_overwrite_hi got=%h want=2", hi); end
        if (lo !== 32'd6) begin n_errors++; $display("FAIL mt_overwrite_lo got=%h want=6", lo); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        int          n;
        @(posedge clk); #1;
        o = OP_DIV; a = $urandom; b = 32'($urandom_range(1, 1000));
        issue_and_wait(o, a, b, n);
        n_checks++;
        if (n != LAT) begin n_errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", n, LAT); end
        for (int i = 0; i < 3; i++) begin
            model(o, a, b, eh, el);
            n_checks += 2;
            if (hi !== eh) begin n_errors++; $display("FAIL b2b%0d_hi got=%h want=%h", i, hi, eh); end
            if (lo !== el) begin n_errors++; $display("FAIL b2b%0d_lo got=%h want=%h", i, lo, el); end
            o = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            start = 1'b1; op = o; rs = a; rt = b;
            @(posedge clk); #1;
            start = 1'b0; rs = $urandom; rt = $urandom;
            wait_done(n);
            n_checks++;
            if (n + 1 != LAT + 1) begin n_errors++; $display("FAIL b2b%0d_spacing got=%0d want=%0d", i, n + 1, LAT + 1); end
        end
        model(o, a, b, eh, el);
        n_checks += 2;
        if (hi !== eh) begin n_errors++; $display("FAIL b2b_last_hi got=%h want=%h", hi, eh); end
        if (lo !== el) begin n_errors++; $display("FAIL b2b_last_lo got=%h want=%h", lo, el); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_mt();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
